// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding and counter defaults.
package pipe_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  localparam int CNT_W_DEF = 32;
  // Holds DRAIN_CYCLES-1 for the legal range 1..15.
  localparam int DRAIN_W   = 4;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard inputs, stage enables/clears and perf counters between the pipeline and its sequencer.
interface pipe_hazard_ctrl_if
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             load_use;
  logic             mispredict;
  logic             halt_req;
  logic             resume;
  logic             pc_en;
  logic             ps1_en;
  logic             ps2_en;
  logic             ps3_en;
  logic             ps4_en;
  logic             ps1_clear;
  logic             ps2_clear;
  logic             ps3_clear;
  logic             ps4_clear;
  logic             pc_restart;
  logic             halted;
  logic [CNT_W-1:0] cnt_cycle;
  logic [CNT_W-1:0] cnt_stall;
  logic [CNT_W-1:0] cnt_flush;

  modport master (
    output load_use, mispredict, halt_req, resume,
    input  pc_en, ps1_en, ps2_en, ps3_en, ps4_en,
    input  ps1_clear, ps2_clear, ps3_clear, ps4_clear,
    input  pc_restart, halted, cnt_cycle, cnt_stall, cnt_flush
  );

  modport slave (
    input  load_use, mispredict, halt_req, resume,
    output pc_en, ps1_en, ps2_en, ps3_en, ps4_en,
    output ps1_clear, ps2_clear, ps3_clear, ps4_clear,
    output pc_restart, halted, cnt_cycle, cnt_stall, cnt_flush
  );
endinterface

// File: rtl/pipe_hazard_ctrl_perf_counter.sv
// Wrap-around event counter, CNT_W wide.
// Counts one per cycle with inc high, value visible the cycle after; no backpressure.
module pipe_hazard_ctrl_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stage en/clear and PC enable for load-use stall, mispredict flush, halt/resume.
// En/clear are combinational from state + hazards; pc_restart and counters are registered.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  pipe_hazard_ctrl_if.slave   bus
);

  state_t               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 restart_q, restart_d;

  logic pc_en, ps1_en, ps2_en, ps3_en, ps4_en;
  logic ps1_clear, ps2_clear, ps3_clear, ps4_clear;
  logic halted, cyc_inc, stall_inc, flush_inc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RUN;
      drain_q   <= '0;
      restart_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      drain_q   <= drain_d;
      restart_q <= restart_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    drain_d   = drain_q;
    restart_d = 1'b0;
    pc_en     = 1'b1;
    ps1_en    = 1'b1;
    ps2_en    = 1'b1;
    ps3_en    = 1'b1;
    ps4_en    = 1'b1;
    ps1_clear = 1'b0;
    ps2_clear = 1'b0;
    ps3_clear = 1'b0;
    ps4_clear = 1'b0;
    halted    = 1'b0;
    cyc_inc   = 1'b1;
    stall_inc = 1'b0;
    flush_inc = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        if (bus.halt_req) begin
          pc_en     = 1'b0;
          ps1_clear = 1'b1;
          ps2_clear = 1'b1;
          drain_d   = DRAIN_W'(DRAIN_CYCLES - 1);
          state_d   = ST_DRAIN;
        end else if (bus.mispredict) begin
          ps1_clear = 1'b1;
          ps2_clear = 1'b1;
          flush_inc = 1'b1;
        end else begin
          // After a restart ID holds a bubble, so any load_use that cycle is spurious.
          if (bus.load_use && !restart_q) begin
            pc_en     = 1'b0;
            ps1_en    = 1'b0;
            ps2_clear = 1'b1;
            stall_inc = 1'b1;
          end
          if (restart_q) begin
            ps1_clear = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        pc_en     = 1'b0;
        ps1_en    = 1'b0;
        ps2_en    = 1'b0;
        ps3_en    = 1'b0;
        ps1_clear = 1'b1;
        ps2_clear = 1'b1;
        ps3_clear = 1'b1;
        if (drain_q == '0) begin
          state_d = ST_HALT;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      ST_HALT: begin
        pc_en   = 1'b0;
        ps1_en  = 1'b0;
        ps2_en  = 1'b0;
        ps3_en  = 1'b0;
        ps4_en  = 1'b0;
        halted  = 1'b1;
        cyc_inc = 1'b0;
        if (bus.resume) begin
          state_d   = ST_RUN;
          restart_d = 1'b1;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  assign bus.pc_en      = pc_en;
  assign bus.ps1_en     = ps1_en;
  assign bus.ps2_en     = ps2_en;
  assign bus.ps3_en     = ps3_en;
  assign bus.ps4_en     = ps4_en;
  assign bus.ps1_clear  = ps1_clear;
  assign bus.ps2_clear  = ps2_clear;
  assign bus.ps3_clear  = ps3_clear;
  assign bus.ps4_clear  = ps4_clear;
  assign bus.halted     = halted;
  assign bus.pc_restart = restart_q;

  pipe_hazard_ctrl_perf_counter #(.CNT_W(CNT_W)) u_cnt_cycle (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cyc_inc),
    .cnt   (bus.cnt_cycle)
  );

  pipe_hazard_ctrl_perf_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .cnt   (bus.cnt_stall)
  );

  pipe_hazard_ctrl_perf_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .cnt   (bus.cnt_flush)
  );

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Two sequencers (DRAIN=2/CNT_W=32 and DRAIN=1/CNT_W=4) driven in lockstep against a cycle-count model.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(32)) bus ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

  pipe_hazard_ctrl #(.DRAIN_CYCLES(2), .CNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  pipe_hazard_ctrl #(.DRAIN_CYCLES(1), .CNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  // {pc_en, ps1..4_en, ps1..4_clear, pc_restart, halted}
  logic [10:0] o0, o1;
  assign o0 = {bus.pc_en, bus.ps1_en, bus.ps2_en, bus.ps3_en, bus.ps4_en,
               bus.ps1_clear, bus.ps2_clear, bus.ps3_clear, bus.ps4_clear,
               bus.pc_restart, bus.halted};
  assign o1 = {bus4.pc_en, bus4.ps1_en, bus4.ps2_en, bus4.ps3_en, bus4.ps4_en,
               bus4.ps1_clear, bus4.ps2_clear, bus4.ps3_clear, bus4.ps4_clear,
               bus4.pc_restart, bus4.halted};

  localparam logic [10:0] V_IDLE  = 11'b1_1111_0000_00;
  localparam logic [10:0] V_STALL = 11'b0_0111_0100_00;
  localparam logic [10:0] V_FLUSH = 11'b1_1111_1100_00;
  localparam logic [10:0] V_HREQ  = 11'b0_1111_1100_00;
  localparam logic [10:0] V_DRAIN = 11'b0_0001_1110_00;
  localparam logic [10:0] V_HALT  = 11'b0_0000_0000_01;
  localparam logic [10:0] V_RST   = 11'b1_1111_1000_10;

  int errors = 0;
  int checks = 0;
  bit lu, mp, hr, rs;

  // Reference model: pipeline mode expressed as remaining drain cycles and a halted flag.
  int          m_drain [2];
  bit          m_halt  [2];
  bit          m_rst   [2];
  logic [31:0] m_cyc   [2];
  logic [31:0] m_stl   [2];
  logic [31:0] m_fls   [2];

  function automatic int drain_of(int i);
    return (i == 0) ? 2 : 1;
  endfunction

  function automatic logic [10:0] model_out(int i);
    bit pc, e1, c1, c2;
    if (m_halt[i]) return V_HALT;
    if (m_drain[i] > 0) return V_DRAIN;
    pc = 1'b1; e1 = 1'b1; c1 = 1'b0; c2 = 1'b0;
    if (hr) begin
      pc = 1'b0; c1 = 1'b1; c2 = 1'b1;
    end else if (mp) begin
      c1 = 1'b1; c2 = 1'b1;
    end else if (m_rst[i]) begin
      c1 = 1'b1;
    end else if (lu) begin
      pc = 1'b0; e1 = 1'b0; c2 = 1'b1;
    end
    return {pc, e1, 3'b111, c1, c2, 2'b00, m_rst[i], 1'b0};
  endfunction

  task automatic model_tick(int i);
    bit run;
    bit new_rst;
    run = !m_halt[i] && (m_drain[i] == 0);
    new_rst = 1'b0;
    if (!m_halt[i]) m_cyc[i] = m_cyc[i] + 1;
    if (run) begin
      if (hr) m_drain[i] = drain_of(i);
      else if (mp) m_fls[i] = m_fls[i] + 1;
      else if (lu && !m_rst[i]) m_stl[i] = m_stl[i] + 1;
    end else if (m_drain[i] > 0) begin
      m_drain[i] = m_drain[i] - 1;
      if (m_drain[i] == 0) m_halt[i] = 1'b1;
    end else if (rs) begin
      m_halt[i] = 1'b0;
      new_rst = 1'b1;
    end
    m_rst[i] = new_rst;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_drain[i] = 0; m_halt[i] = 1'b0; m_rst[i] = 1'b0;
      m_cyc[i] = '0; m_stl[i] = '0; m_fls[i] = '0;
    end
  endtask

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all(string tag);
    chk({tag, ".out0"}, 128'(o0), 128'(model_out(0)));
    chk({tag, ".cnt0"}, 128'({bus.cnt_cycle, bus.cnt_stall, bus.cnt_flush}),
        128'({m_cyc[0], m_stl[0], m_fls[0]}));
    chk({tag, ".out1"}, 128'(o1), 128'(model_out(1)));
    chk({tag, ".cnt1"}, 128'({bus4.cnt_cycle, bus4.cnt_stall, bus4.cnt_flush}),
        128'({m_cyc[1][3:0], m_stl[1][3:0], m_fls[1][3:0]}));
  endtask

  task automatic drive(bit l, bit m, bit h, bit r);
    lu = l; mp = m; hr = h; rs = r;
    bus.load_use = l;  bus.mispredict = m;  bus.halt_req = h;  bus.resume = r;
    bus4.load_use = l; bus4.mispredict = m; bus4.halt_req = h; bus4.resume = r;
  endtask

  // Called #1 after a rising edge; ends #1 after the next one.
  task automatic step(string tag, bit l, bit m, bit h, bit r);
    drive(l, m, h, r);
    @(negedge clk);
    compare_all(tag);
    @(posedge clk);
    model_tick(0);
    model_tick(1);
    #1;
  endtask

  task automatic async_reset(string tag);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_all(tag);
    chk({tag, ".halted"}, 128'(bus.halted), 128'(0));
    chk({tag, ".restart"}, 128'(bus.pc_restart), 128'(0));
    chk({tag, ".cyc"}, 128'(bus.cnt_cycle), 128'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          l, m, h, r;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl [12];

  initial begin
    tbl[0]  = '{0, 0, 0, 0, V_IDLE};
    tbl[1]  = '{1, 0, 0, 0, V_STALL};
    tbl[2]  = '{0, 0, 0, 0, V_IDLE};
    tbl[3]  = '{1, 1, 0, 0, V_FLUSH};
    tbl[4]  = '{0, 0, 1, 1, V_HREQ};
    tbl[5]  = '{1, 1, 0, 0, V_DRAIN};
    tbl[6]  = '{0, 0, 0, 0, V_DRAIN};
    tbl[7]  = '{0, 0, 0, 0, V_HALT};
    tbl[8]  = '{1, 1, 1, 0, V_HALT};
    tbl[9]  = '{0, 0, 0, 1, V_HALT};
    tbl[10] = '{0, 0, 0, 0, V_RST};
    tbl[11] = '{0, 0, 0, 0, V_IDLE};

    model_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    compare_all("reset");
    chk("reset.vec", 128'(o0), 128'(V_IDLE));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) step("idle", 0, 0, 0, 0);
    chk("cyc10", 128'(bus.cnt_cycle), 128'(10));
    chk("stall0", 128'(bus.cnt_stall), 128'(0));
    chk("flush0", 128'(bus.cnt_flush), 128'(0));
    for (int i = 0; i < 6; i++) step("idle", 0, 0, 0, 0);
    chk("cyc16", 128'(bus.cnt_cycle), 128'(16));
    chk("wrap4", 128'(bus4.cnt_cycle), 128'(0));

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].l, tbl[i].m, tbl[i].h, tbl[i].r);
      @(negedge clk);
      chk($sformatf("tbl%0d", i), 128'(o0), 128'(tbl[i].exp));
      compare_all("tbl");
      @(posedge clk);
      model_tick(0);
      model_tick(1);
      #1;
    end
    chk("tbl.stall", 128'(bus.cnt_stall), 128'(1));
    chk("tbl.flush", 128'(bus.cnt_flush), 128'(1));
    chk("tbl.cyc", 128'(bus.cnt_cycle), 128'(25));

    step("hreq", 0, 0, 1, 0);
    step("drain", 0, 0, 0, 0);
    step("drain", 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step("halt_idle", 0, 0, 0, 0);
    chk("halt.frozen", 128'(bus.cnt_cycle), 128'(28));
    chk("halt.halted", 128'(bus.halted), 128'(1));
    step("resume", 0, 0, 0, 1);
    chk("restart.pulse", 128'(bus.pc_restart), 128'(1));
    chk("restart.clr1", 128'(bus.ps1_clear), 128'(1));
    chk("restart.halted", 128'(bus.halted), 128'(0));
    step("post_restart", 0, 0, 0, 0);

    step("hreq2", 0, 0, 1, 0);
    step("drain2", 0, 0, 0, 0);
    async_reset("rst_drain");
    step("resume_run", 0, 0, 0, 1);
    chk("resume_run.restart", 128'(bus.pc_restart), 128'(0));
    chk("resume_run.cyc", 128'(bus.cnt_cycle), 128'(1));

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd", $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
             $urandom_range(0, 29) == 0, $urandom_range(0, 6) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencer for the 5-stage pipeline registers: PS1 (IF/ID), PS2 (ID/EX), PS3 (EX/MEM), PS4 (MEM/WB).
- Generates every stage's en/clear, plus PC enable.
- Resolves load-use stalls, branch/jump mispredict flushes and syscall-halt drain/halt/resume.
- Keeps wrap-around performance counters (cycles, stalls, flushes) for the display/debug path.

Parameters:
- DRAIN_CYCLES, 2, bubble cycles spent draining PS3/PS4 after a halt syscall leaves EX; legal 1..15
- CNT_W, 32, width of each performance counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- load_use  in  1  ID instruction reads rt/rs written by a load currently in EX
- mispredict  in  1  EX-resolved branch/jump target differs from pc_guessed
- halt_req  in  1  halt syscall (syscall_en with halt code) is in EX this cycle
- resume  in  1  single-cycle go pulse from the board
- pc_en  out  1  PC register update enable
- ps1_en, ps2_en, ps3_en, ps4_en  out  1 each  stage latch enables
- ps1_clear, ps2_clear, ps3_clear, ps4_clear  out  1 each  stage synchronous clear (bubble)
- pc_restart  out  1  one-cycle pulse: PC loads saved syscall pc_4
- halted  out  1  high in HALT state
- cnt_cycle, cnt_stall, cnt_flush  out  CNT_W each  performance counters

Behaviour:
- Outputs are combinational from state + inputs, except counters and pc_restart, which are registered.
- Reset: state=RUN, drain counter=0, all counters=0, pc_restart=0.
- States: RUN, DRAIN, HALT.
- RUN default: all en=1, all clear=0, pc_en=1.
- RUN priority 1, halt_req:
  - pc_en=0; ps1_clear=1; ps2_clear=1; ps3_en=1; ps4_en=1.
  - Save "restart pending"; load drain counter with DRAIN_CYCLES-1; next state DRAIN.
- RUN priority 2, mispredict:
  - ps1_clear=1, ps2_clear=1; pc_en=1 (corrected target loads); ps3/ps4 en=1.
  - cnt_flush+1.
  - A simultaneous load_use is ignored because the ID instruction is wrong-path.
- RUN priority 3, load_use:
  - pc_en=0, ps1_en=0 (hold); ps2_clear=1; ps3/ps4 en=1; cnt_stall+1.
  - Exactly one bubble per assertion; the upstream detector deasserts after the bubble.
- DRAIN:
  - pc_en=0; ps1/ps2/ps3 clear=1; ps4_en=1. Inputs load_use and mispredict are ignored.
  - Drain counter decrements each cycle; at 0, next state HALT.
  - DRAIN_CYCLES=1 means exactly one DRAIN cycle.
- HALT:
  - All en=0, all clear=0, pc_en=0; halted=1. Pipeline contents are frozen.
  - On resume: next state RUN; pc_restart=1 for the first RUN cycle.
  - During that first RUN cycle, ps1_clear=1 and pc_en=1 so the restart fetch is clean.
- resume is ignored outside HALT. halt_req is ignored outside RUN.
- Counters:
  - cnt_cycle increments every cycle in RUN and DRAIN, never in HALT.
  - cnt_stall increments on a load_use bubble; cnt_flush increments on a mispredict flush.
  - All counters wrap modulo 2^CNT_W; no saturation.
- Async reset mid-DRAIN or mid-HALT returns to RUN immediately with counters zeroed. No pc_restart pulse is emitted.
- Clear takes precedence over en at each stage register; this block never asserts both on the same stage except where stated above.

Decomposition:
- Shared core header: state encodings (RUN=2'd0, DRAIN=2'd1, HALT=2'd2) and the default CNT_W.
- One natural sub-module: perf_counter (enable, wrap, CNT_W-wide), instantiated three times.
- FSM and en/clear decode stay in pipe_hazard_ctrl.

Test Plan:
- Reset release, no inputs for 10 cycles -> all en=1, clears=0, pc_en=1; cnt_cycle=10, cnt_stall=0, cnt_flush=0.
- load_use for 1 cycle -> that cycle pc_en=0, ps1_en=0, ps2_clear=1, ps3_en=ps4_en=1; cnt_stall=1; next cycle all en=1.
- mispredict and load_use in the same cycle -> ps1_clear=ps2_clear=1, pc_en=1, ps1_en unchanged at 1; cnt_flush=1, cnt_stall=0.
- halt_req with DRAIN_CYCLES=2 -> cycle0 ps1/ps2 clear; cycles1-2 DRAIN (ps3_clear=1, ps4_en=1); cycle3 halted=1 with all en=0. Then:
  - 20 idle cycles: cnt_cycle frozen.
  - resume pulse: next cycle pc_restart=1, ps1_clear=1, halted=0.
- rst_n low during DRAIN -> immediately RUN, counters=0, halted=0, no pc_restart. resume pulsed in RUN -> no effect.
- Counter wrap with CNT_W=4 -> after 16 RUN cycles, cnt_cycle=0.
